ofdm_cp_insert: RTL

Cyclic-prefix inserter for the OFDM transmit path; sits directly downstream of the IFFT bit-reverse stage. It captures each natural-order time-domain symbol (one complex sample per i_ce, first sample flagged by i_sync) into a two-bank ping-pong buffer. It then emits the last CPLEN samples followed by the full SIZE-sample symbol on a valid/ready stream toward the DAC/interpolation path.

---
 rtl/ofdm_cp_insert.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: ping-pong captures natural-order OFDM symbols and replays
// the last CPLEN samples followed by the whole symbol on a valid/ready stream.
module ofdm_cp_insert #(
    parameter int LGSIZE = 6,
    parameter int WIDTH  = 16,
    parameter int CPLEN  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic               i_sync,
    input  logic [2*WIDTH-1:0] i_in,
    output logic               o_in_ready,
    output logic [2*WIDTH-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_err
);
    localparam int                SIZE      = 1 << LGSIZE;
    localparam logic [LGSIZE-1:0] CP_START  = LGSIZE'(SIZE - CPLEN);
    localparam logic [LGSIZE-1:0] ADDR_MAX  = LGSIZE'(SIZE - 1);
    localparam logic [LGSIZE:0]   LAST_BEAT = (LGSIZE + 1)'(SIZE + CPLEN - 1);

    typedef enum logic {W_WAIT, W_FILL} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_CP, R_BODY} rstate_t;

    logic [2*WIDTH-1:0] r_mem [0:2*SIZE-1];
    logic [1:0]         r_full;
    logic               r_wb, r_rb;
    wstate_t            r_wstate;
    logic [LGSIZE-1:0]  r_wcnt;
    rstate_t            r_rstate;
    logic [LGSIZE-1:0]  r_ridx;
    logic [LGSIZE:0]    r_beat;
    logic [2*WIDTH-1:0] r_data;
    logic               r_valid, r_last, r_err;

    logic               w_start, w_we, w_wdone, w_hs, w_rdone, w_next_rb;
    logic [LGSIZE:0]    w_waddr;
    logic [LGSIZE-1:0]  w_ridx_inc;
    logic [LGSIZE:0]    w_beat_inc;
    logic [1:0]         w_full_next;

    // A sync either opens a free bank or restarts the bank being filled at address 0.
    assign w_start    = i_ce && i_sync &&
                        ((r_wstate == W_WAIT && !r_full[r_wb]) || r_wstate == W_FILL);
    assign w_we       = w_start || (i_ce && r_wstate == W_FILL);
    assign w_waddr    = {r_wb, (w_start ? {LGSIZE{1'b0}} : r_wcnt)};
    assign w_wdone    = i_ce && !i_sync && r_wstate == W_FILL && r_wcnt == ADDR_MAX;
    assign w_hs       = r_valid && i_ready;
    assign w_rdone    = w_hs && r_beat == LAST_BEAT;
    assign w_next_rb  = ~r_rb;
    assign w_ridx_inc = r_ridx + 1'b1;
    assign w_beat_inc = r_beat + 1'b1;

    always_ff @(posedge i_clk) begin
        if (w_we)
            r_mem[w_waddr] <= i_in;
    end

    // Completing a write and freeing by read never target the same bank on one edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign w_full_next[gi] = (w_wdone && r_wb == 1'(gi)) ? 1'b1 :
                                     (w_rdone && r_rb == 1'(gi)) ? 1'b0 : r_full[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_full <= 2'b00;
        else
            r_full <= w_full_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wstate <= W_WAIT;
            r_wcnt   <= '0;
            r_wb     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_wstate)
                W_WAIT: begin
                    if (i_ce && i_sync) begin
                        if (!r_full[r_wb]) begin
                            r_wstate <= W_FILL;
                            r_wcnt   <= LGSIZE'(1);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                W_FILL: begin
                    if (i_ce) begin
                        if (i_sync) begin
                            r_err  <= 1'b1;
                            r_wcnt <= LGSIZE'(1);
                        end else if (r_wcnt == ADDR_MAX) begin
                            r_wb     <= ~r_wb;
                            r_wstate <= W_WAIT;
                            r_wcnt   <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                default: r_wstate <= W_WAIT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rstate <= R_IDLE;
            r_rb     <= 1'b0;
            r_ridx   <= '0;
            r_beat   <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_full[r_rb]) begin
                        r_data   <= r_mem[{r_rb, CP_START}];
                        r_ridx   <= CP_START;
                        r_beat   <= '0;
                        r_valid  <= 1'b1;
                        r_last   <= 1'b0;
                        r_rstate <= R_CP;
                    end
                end
                R_CP, R_BODY: begin
                    if (w_rdone) begin
                        r_rb <= w_next_rb;
                        // Chain straight into the other bank so back-to-back symbols have no gap.
                        if (r_full[w_next_rb]) begin
                            r_data   <= r_mem[{w_next_rb, CP_START}];
                            r_ridx   <= CP_START;
                            r_beat   <= '0;
                            r_last   <= 1'b0;
                            r_rstate <= R_CP;
                        end else begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_rstate <= R_IDLE;
                        end
                    end else if (w_hs) begin
                        r_ridx <= w_ridx_inc;
                        r_beat <= w_beat_inc;
                        r_data <= r_mem[{r_rb, w_ridx_inc}];
                        r_last <= (w_beat_inc == LAST_BEAT);
                        if (r_rstate == R_CP && w_ridx_inc == '0)
                            r_rstate <= R_BODY;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign o_in_ready = (r_wstate == W_FILL) || !r_full[r_wb];
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_err      = r_err;
endmodule
